// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - architectural PC owner: branch/jalr redirect, fetch handshake, flush and misaligned trap
// State register, next-state logic and registered outputs with next values computed in a separate comb block.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             PCAsrc,
  input  logic             PCBsrc,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  input  logic             stall,
  input  logic             if_ready,
  input  logic             trap_clear,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             flush,
  output logic             trap,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [3:0]       fcnt, fcnt_d;
  logic [31:0]      pc_d, trap_pc_d;
  logic             pc_valid_d, flush_d, trap_d;
  logic [CNT_W-1:0] cnt_d;

  logic [31:0] sum, target;
  logic        redirect, misaligned, fire;

  // jalr targets drop bit 0; the alignment check then runs on the cleaned address
  assign sum        = (PCAsrc ? imm : 32'd4) + (PCBsrc ? rs1 : br_pc);
  assign target     = {sum[31:1], sum[0] & ~PCBsrc};
  assign redirect   = br_valid & (PCAsrc | PCBsrc) & (state == S_RUN);
  assign misaligned = |target[1:0];
  assign fire       = pc_valid & if_ready & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_RUN:   if (redirect) state_d = misaligned ? S_TRAP : S_FLUSH;
      S_FLUSH: if (fcnt == 4'd0) state_d = S_RUN;
      S_TRAP:  if (trap_clear) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_d       = pc;
    pc_valid_d = pc_valid;
    flush_d    = flush;
    trap_d     = trap;
    trap_pc_d  = trap_pc;
    cnt_d      = redirect_cnt;
    fcnt_d     = fcnt;
    case (state)
      S_RUN: begin
        if (redirect) begin
          pc_valid_d = 1'b0;
          flush_d    = 1'b1;
          if (misaligned) begin
            trap_d    = 1'b1;
            trap_pc_d = target;
          end else begin
            pc_d   = target;
            fcnt_d = FLUSH_LOAD;
            if (!(&redirect_cnt)) cnt_d = redirect_cnt + CNT_ONE;
          end
        end else begin
          // pc_valid rises on the first edge after reset and stays up in RUN
          pc_valid_d = 1'b1;
          if (fire) pc_d = pc + 32'd4;
        end
      end
      S_FLUSH: begin
        if (fcnt == 4'd0) begin
          flush_d    = 1'b0;
          pc_valid_d = 1'b1;
        end else begin
          fcnt_d = fcnt - 4'd1;
        end
      end
      S_TRAP: begin
        flush_d    = 1'b0;
        pc_valid_d = 1'b0;
        if (trap_clear) begin
          trap_d     = 1'b0;
          pc_d       = TRAP_VEC;
          pc_valid_d = 1'b1;
        end
      end
      default: begin
        flush_d    = 1'b0;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      pc_valid     <= 1'b0;
      flush        <= 1'b0;
      trap         <= 1'b0;
      trap_pc      <= 32'd0;
      redirect_cnt <= '0;
      fcnt         <= 4'd0;
    end else begin
      pc           <= pc_d;
      pc_valid     <= pc_valid_d;
      flush        <= flush_d;
      trap         <= trap_d;
      trap_pc      <= trap_pc_d;
      redirect_cnt <= cnt_d;
      fcnt         <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - scoreboard bench for next_pc_unit; observation word is {pc, pc_valid, flush, trap}
module tb_next_pc_unit;

  localparam int CNT_W = 3;

  logic             clk, rst_n;
  logic             br_valid, PCAsrc, PCBsrc, stall, if_ready, trap_clear;
  logic [31:0]      br_pc, imm, rs1;
  logic [31:0]      pc, trap_pc;
  logic             pc_valid, flush, trap;
  logic [CNT_W-1:0] redirect_cnt;

  logic [34:0] obs;
  logic [34:0] q[$];
  logic [34:0] e;
  int n_cmp = 0;
  int n_bad = 0;

  assign obs = {pc, pc_valid, flush, trap};

  next_pc_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .PCAsrc(PCAsrc), .PCBsrc(PCBsrc),
    .br_pc(br_pc), .imm(imm), .rs1(rs1), .stall(stall), .if_ready(if_ready),
    .trap_clear(trap_clear), .pc(pc), .pc_valid(pc_valid), .flush(flush), .trap(trap),
    .trap_pc(trap_pc), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; br_valid = 0; PCAsrc = 0; PCBsrc = 0; stall = 0; if_ready = 0;
    trap_clear = 0; br_pc = 0; imm = 0; rs1 = 0;
    tick(); tick();
    n_cmp++;
    if (obs !== 35'd0 || trap_pc !== 32'd0 || redirect_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL reset: got obs=%h trap_pc=%h cnt=%0d want 0/0/0", obs, trap_pc, redirect_cnt);
    end
    rst_n = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      q.push_back({32'(c * 4), 1'b1, 1'b0, 1'b0});
      tick();
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL seq[%0d]: got %h want %h", c, obs, e); end
    end
    n_cmp++;
    if (redirect_cnt !== 3'd0) begin n_bad++; $display("FAIL seq_cnt: got %0d want 0", redirect_cnt); end
  endtask

  task automatic test_branch();
    logic [34:0] ev [4] = '{{32'h60, 3'b010}, {32'h60, 3'b010}, {32'h60, 3'b100}, {32'h64, 3'b100}};
    PCAsrc = 1; PCBsrc = 0; br_pc = 32'h40; imm = 32'h20;
    for (int c = 0; c < 4; c++) begin
      br_valid = (c == 0);
      q.push_back(ev[c]);
      tick();
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL branch[%0d]: got %h want %h", c, obs, e); end
    end
    n_cmp++;
    if (redirect_cnt !== 3'd1) begin n_bad++; $display("FAIL branch_cnt: got %0d want 1", redirect_cnt); end
  endtask

  task automatic test_jalr();
    logic [34:0] ev [3] = '{{32'h1004, 3'b010}, {32'h1004, 3'b010}, {32'h1004, 3'b100}};
    PCAsrc = 1; PCBsrc = 1; rs1 = 32'h1001; imm = 32'h3;
    for (int c = 0; c < 3; c++) begin
      br_valid = (c == 0);
      q.push_back(ev[c]);
      tick();
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL jalr[%0d]: got %h want %h", c, obs, e); end
    end
    n_cmp++;
    if (redirect_cnt !== 3'd2) begin n_bad++; $display("FAIL jalr_cnt: got %0d want 2", redirect_cnt); end
  endtask

  task automatic test_stall_redirect();
    logic [34:0] ev [6] = '{{32'h210, 3'b010}, {32'h210, 3'b010}, {32'h210, 3'b100},
                            {32'h210, 3'b100}, {32'h214, 3'b100}, {32'h218, 3'b100}};
    if_ready = 1; PCBsrc = 0;
    for (int c = 0; c < 6; c++) begin
      stall    = (c <= 3);
      br_valid = (c <= 1) || (c == 5);
      PCAsrc   = (c != 5);
      br_pc    = (c == 0) ? 32'h200 : 32'h300;
      imm      = (c == 0) ? 32'h10 : 32'h8;
      q.push_back(ev[c]);
      tick();
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL stall_redir[%0d]: got %h want %h", c, obs, e); end
    end
    br_valid = 0; stall = 0;
    n_cmp++;
    if (redirect_cnt !== 3'd3) begin n_bad++; $display("FAIL stall_cnt: got %0d want 3", redirect_cnt); end
  endtask

  task automatic test_trap();
    logic [34:0] ev [5] = '{{32'h218, 3'b011}, {32'h218, 3'b001}, {32'h218, 3'b001},
                            {32'h100, 3'b100}, {32'h104, 3'b100}};
    PCAsrc = 1; PCBsrc = 0;
    for (int c = 0; c < 5; c++) begin
      br_valid   = (c == 0) || (c == 2);
      br_pc      = (c == 0) ? 32'h10 : 32'h40;
      imm        = (c == 0) ? 32'h2 : 32'h20;
      trap_clear = (c == 3);
      q.push_back(ev[c]);
      tick();
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL trap[%0d]: got %h want %h", c, obs, e); end
    end
    br_valid = 0; trap_clear = 0;
    n_cmp++;
    if (trap_pc !== 32'h12 || redirect_cnt !== 3'd3) begin
      n_bad++;
      $display("FAIL trap_pc: got %h cnt=%0d want 00000012 cnt=3", trap_pc, redirect_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [34:0] ev [4] = '{{32'hFFFF_FFFC, 3'b010}, {32'hFFFF_FFFC, 3'b010},
                            {32'hFFFF_FFFC, 3'b100}, {32'h0, 3'b100}};
    PCAsrc = 1; PCBsrc = 0; br_pc = 32'hFFFF_FFF0; imm = 32'hC;
    for (int c = 0; c < 4; c++) begin
      br_valid = (c == 0);
      q.push_back(ev[c]);
      tick();
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL wrap[%0d]: got %h want %h", c, obs, e); end
    end
    n_cmp++;
    if (redirect_cnt !== 3'd4) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 4", redirect_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    PCAsrc = 0; PCBsrc = 1; rs1 = 32'h7C; br_valid = 1;
    q.push_back({32'h80, 3'b010});
    tick();
    br_valid = 0;
    e = q.pop_front(); n_cmp++;
    if (obs !== e || redirect_cnt !== 3'd5) begin
      n_bad++; $display("FAIL pre_rst: got %h cnt=%0d want %h cnt=5", obs, redirect_cnt, e);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 35'd0 || trap_pc !== 32'd0 || redirect_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL async_rst: got obs=%h trap_pc=%h cnt=%0d want 0/0/0", obs, trap_pc, redirect_cnt);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      q.push_back({32'(c * 4), 3'b100});
      tick();
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL post_rst[%0d]: got %h want %h", c, obs, e); end
    end
  endtask

  task automatic test_saturate();
    PCAsrc = 1; PCBsrc = 0; br_pc = 32'h1000; imm = 32'h40;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 3; c++) begin
        br_valid = (c == 0);
        tick();
      end
      q.push_back({32'h1040, 3'b100});
      e = q.pop_front(); n_cmp++;
      if (obs !== e || redirect_cnt !== 3'((k + 1 > 7) ? 7 : k + 1)) begin
        n_bad++;
        $display("FAIL sat[%0d]: got %h cnt=%0d want %h cnt=%0d", k, obs, redirect_cnt, e,
                 (k + 1 > 7) ? 7 : k + 1);
      end
    end
    br_valid = 0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_stall_redirect();
    test_trap();
    test_wrap();
    test_reset_mid_flush();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
